mem_issue_throttle_ctrl: RTL and testbench

//  Scheduler for the issue-stage reorder buffer: decides cycle by cycle whether a load/store may pass
//  to the scoreboard or must be held back so a non-memory instruction overtakes it. Enforces a minimum
//  gap between consecutive memory ops, backs off while the LSU is busy, and bounds hold time (no starvation).

---
 rtl/ariane_pkg.sv | 11 +
 rtl/sat_counter.sv | 26 ++
 rtl/mem_issue_throttle_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_issue_throttle_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// Shared issue-stage types: state encoding for the memory-op issue throttle.
package ariane_pkg;

  typedef enum logic [1:0] {
    THR_IDLE    = 2'd0,
    THR_GAP     = 2'd1,
    THR_BACKOFF = 2'd2,
    THR_STARVE  = 2'd3
  } mem_throttle_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: sticks at all-ones instead of wrapping; clr_i beats inc_i.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (clr_i) begin
      r_count <= '0;
    end else if (inc_i && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/mem_issue_throttle_ctrl.sv
// Issue-stage memory-op throttle: enforces a gap between mem ops, backs off while the LSU is busy,
// and force-releases a held mem op after MaxHold cycles so it cannot starve.
module mem_issue_throttle_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned MinGap   = 2,
  parameter int unsigned MaxHold  = 16,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                debug_req_i,
  input  logic                en_i,
  input  logic                issue_valid_i,
  input  logic                issue_ack_i,
  input  logic                issue_is_mem_i,
  input  logic                lsu_ready_i,
  output logic                hold_mem_o,
  output logic [1:0]          state_o,
  output logic [CntWidth-1:0] hold_cycles_o,
  output logic [CntWidth-1:0] starve_events_o
);

  localparam int unsigned GapW  = $clog2(MinGap + 1);
  localparam int unsigned HoldW = $clog2(MaxHold + 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(MinGap - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(MaxHold - 1);

  if (MinGap < 1 || MaxHold <= MinGap) begin : gen_bad_params
    $error("mem_issue_throttle_ctrl: need MinGap >= 1 and MaxHold > MinGap");
  end

  mem_throttle_state_e r_state, w_state_d;
  logic [GapW-1:0]     r_gap, w_gap_d;
  logic [HoldW-1:0]    r_hold, w_hold_d;
  logic                r_hold_mem, w_hold_mem_d;
  logic                w_mem_fire, w_mem_pend, w_force_idle, w_starve, w_starve_enter;
  logic                w_holding_now, w_holding_next;

  assign w_mem_fire   = issue_valid_i & issue_ack_i & issue_is_mem_i;
  assign w_mem_pend   = issue_valid_i & issue_is_mem_i & ~issue_ack_i;
  assign w_force_idle = flush_i | debug_req_i | ~en_i;
  assign w_starve     = (r_hold == HoldLast) & w_mem_pend;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= THR_IDLE;
      r_gap      <= '0;
      r_hold     <= '0;
      r_hold_mem <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_gap      <= w_gap_d;
      r_hold     <= w_hold_d;
      r_hold_mem <= w_hold_mem_d;
    end
  end

  // Starvation outranks the normal GAP/BACKOFF exits so a held op is always released in bounded time.
  always_comb begin
    w_state_d      = r_state;
    w_gap_d        = r_gap;
    w_starve_enter = 1'b0;
    if (w_force_idle) begin
      w_state_d = THR_IDLE;
      w_gap_d   = '0;
    end else begin
      case (r_state)
        THR_IDLE: begin
          if (w_mem_fire) begin
            w_state_d = THR_GAP;
            w_gap_d   = '0;
          end
        end
        THR_GAP: begin
          if (w_starve) begin
            w_state_d      = THR_STARVE;
            w_gap_d        = '0;
            w_starve_enter = 1'b1;
          end else if (w_mem_fire) begin
            w_gap_d = '0;
          end else if (r_gap == GapLast) begin
            w_state_d = lsu_ready_i ? THR_IDLE : THR_BACKOFF;
            w_gap_d   = '0;
          end else begin
            w_gap_d = r_gap + 1'b1;
          end
        end
        THR_BACKOFF: begin
          if (w_starve) begin
            w_state_d      = THR_STARVE;
            w_starve_enter = 1'b1;
          end else if (lsu_ready_i) begin
            w_state_d = THR_IDLE;
          end else if (w_mem_fire) begin
            w_state_d = THR_GAP;
            w_gap_d   = '0;
          end
        end
        THR_STARVE: begin
          if (w_mem_fire) begin
            w_state_d = THR_GAP;
            w_gap_d   = '0;
          end
        end
        default: begin
          w_state_d = THR_IDLE;
          w_gap_d   = '0;
        end
      endcase
    end
  end

  assign w_holding_now  = (r_state == THR_GAP) || (r_state == THR_BACKOFF);
  assign w_holding_next = (w_state_d == THR_GAP) || (w_state_d == THR_BACKOFF);

  // hold_q only accumulates while a mem op keeps waiting inside the holding states.
  always_comb begin
    w_hold_d = '0;
    if (w_holding_now && w_holding_next && w_mem_pend) begin
      w_hold_d = (r_hold == HoldLast) ? r_hold : r_hold + 1'b1;
    end
  end

  always_comb begin
    w_hold_mem_d = w_holding_next;
  end

  assign hold_mem_o = r_hold_mem;
  assign state_o    = r_state;

  sat_counter #(
    .Width (CntWidth)
  ) u_hold_cycles (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (r_hold_mem & w_mem_pend),
    .clr_i   (1'b0),
    .count_o (hold_cycles_o)
  );

  sat_counter #(
    .Width (CntWidth)
  ) u_starve_events (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (w_starve_enter),
    .clr_i   (1'b0),
    .count_o (starve_events_o)
  );

endmodule

// File: tb/tb_mem_issue_throttle_ctrl.sv
// Scoreboard bench for mem_issue_throttle_ctrl: directed vectors queue hand-computed
// post-edge outputs, a monitor pops and compares them after each rising edge.
module tb_mem_issue_throttle_ctrl;

  // Input vector layout: {flush, debug, en, valid, ack, is_mem, lsu_ready}
  localparam logic [6:0] IDL_R      = 7'b0010001;
  localparam logic [6:0] IDL_N      = 7'b0010000;
  localparam logic [6:0] FIRE_R     = 7'b0011111;
  localparam logic [6:0] FIRE_N     = 7'b0011110;
  localparam logic [6:0] PEND_N     = 7'b0011010;
  localparam logic [6:0] PEND_R     = 7'b0011011;
  localparam logic [6:0] FLUSH_FIRE = 7'b1011111;
  localparam logic [6:0] DBG_FIRE   = 7'b0111111;
  localparam logic [6:0] DBG_IDLE   = 7'b0110001;
  localparam logic [6:0] NOEN_FIRE  = 7'b0001111;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       flush_i = 1'b0, debug_req_i = 1'b0, en_i = 1'b0;
  logic       issue_valid_i = 1'b0, issue_ack_i = 1'b0, issue_is_mem_i = 1'b0, lsu_ready_i = 1'b0;
  logic       hold_mem_o;
  logic [1:0] state_o;
  logic [3:0] hold_cycles_o, starve_events_o;

  typedef struct {
    int          id;
    logic [10:0] exp;
  } sb_item_t;

  sb_item_t sbQ[$];
  sb_item_t monItem;
  int nChecks = 0;
  int nPass   = 0;
  int stepId  = 0;

  wire [10:0] actual = {hold_mem_o, state_o, hold_cycles_o, starve_events_o};

  mem_issue_throttle_ctrl #(
    .MinGap   (2),
    .MaxHold  (16),
    .CntWidth (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .debug_req_i     (debug_req_i),
    .en_i            (en_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ack_i     (issue_ack_i),
    .issue_is_mem_i  (issue_is_mem_i),
    .lsu_ready_i     (lsu_ready_i),
    .hold_mem_o      (hold_mem_o),
    .state_o         (state_o),
    .hold_cycles_o   (hold_cycles_o),
    .starve_events_o (starve_events_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [10:0] ex(input logic h, input logic [1:0] s, input int hc, input int se);
    return {h, s, 4'(hc), 4'(se)};
  endfunction

  task automatic checkOutput(input int id, input logic [10:0] act, input logic [10:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL step %0d: got hold=%0b state=%0d hold_cycles=%0d starve=%0d, expected hold=%0b state=%0d hold_cycles=%0d starve=%0d",
               id, act[10], act[9:8], act[7:4], act[3:0], exp[10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] vec, input logic [10:0] exp);
    @(negedge clk_i);
    {flush_i, debug_req_i, en_i, issue_valid_i, issue_ack_i, issue_is_mem_i, lsu_ready_i} = vec;
    stepId++;
    sbQ.push_back('{stepId, exp});
  endtask

  task automatic waitDrain();
    int k = 0;
    while (sbQ.size() > 0 && k < 20) begin
      @(posedge clk_i);
      #3;
      k++;
    end
    if (sbQ.size() > 0) begin
      nChecks++;
      $display("[TB] FAIL drain: %0d expectations pending, required 0", sbQ.size());
      sbQ.delete();
    end
  endtask

  task automatic doReset();
    waitDrain();
    @(negedge clk_i);
    rst_ni = 1'b0;
    {flush_i, debug_req_i, en_i, issue_valid_i, issue_ack_i, issue_is_mem_i, lsu_ready_i} = 7'($urandom);
    #2;
    stepId++;
    checkOutput(stepId, actual, 11'b0);
    @(negedge clk_i);
    {flush_i, debug_req_i, en_i, issue_valid_i, issue_ack_i, issue_is_mem_i, lsu_ready_i} = IDL_R;
    rst_ni = 1'b1;
  endtask

  always @(posedge clk_i) begin
    #2;
    if (sbQ.size() > 0) begin
      monItem = sbQ.pop_front();
      checkOutput(monItem.id, actual, monItem.exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Gap with LSU ready: hold for two cycles then back to IDLE
    doReset();
    applyStimulus(FIRE_R, ex(1, 1, 0, 0));
    applyStimulus(IDL_R,  ex(1, 1, 0, 0));
    applyStimulus(IDL_R,  ex(0, 0, 0, 0));
    applyStimulus(IDL_R,  ex(0, 0, 0, 0));

    // Backoff: LSU busy until the seventh vector; only pending cycles are counted
    doReset();
    applyStimulus(FIRE_N, ex(1, 1, 0, 0));
    applyStimulus(PEND_N, ex(1, 1, 1, 0));
    applyStimulus(IDL_N,  ex(1, 2, 1, 0));
    applyStimulus(PEND_N, ex(1, 2, 2, 0));
    applyStimulus(IDL_N,  ex(1, 2, 2, 0));
    applyStimulus(PEND_N, ex(1, 2, 3, 0));
    applyStimulus(PEND_R, ex(0, 0, 4, 0));
    applyStimulus(PEND_R, ex(0, 0, 4, 0));

    // Mem fire inside GAP restarts the gap; mem fire in BACKOFF re-enters GAP
    doReset();
    applyStimulus(FIRE_R, ex(1, 1, 0, 0));
    applyStimulus(FIRE_R, ex(1, 1, 0, 0));
    applyStimulus(IDL_R,  ex(1, 1, 0, 0));
    applyStimulus(IDL_R,  ex(0, 0, 0, 0));
    applyStimulus(FIRE_N, ex(1, 1, 0, 0));
    applyStimulus(IDL_N,  ex(1, 1, 0, 0));
    applyStimulus(IDL_N,  ex(1, 2, 0, 0));
    applyStimulus(FIRE_N, ex(1, 1, 0, 0));
    applyStimulus(IDL_N,  ex(1, 1, 0, 0));
    applyStimulus(IDL_N,  ex(1, 2, 0, 0));
    applyStimulus(IDL_R,  ex(0, 0, 0, 0));

    // Starvation release, hold_cycles saturating at 15, then flush/debug/disable
    doReset();
    applyStimulus(FIRE_N, ex(1, 1, 0, 0));
    applyStimulus(PEND_N, ex(1, 1, 1, 0));
    for (int k = 2; k <= 15; k++) begin
      applyStimulus(PEND_N, ex(1, 2, k, 0));
    end
    applyStimulus(PEND_N, ex(0, 3, 15, 1));
    for (int k = 0; k < 4; k++) begin
      applyStimulus(PEND_N, ex(0, 3, 15, 1));
    end
    applyStimulus(FIRE_N,     ex(1, 1, 15, 1));
    applyStimulus(FLUSH_FIRE, ex(0, 0, 15, 1));
    applyStimulus(DBG_FIRE,   ex(0, 0, 15, 1));
    applyStimulus(DBG_FIRE,   ex(0, 0, 15, 1));
    applyStimulus(DBG_FIRE,   ex(0, 0, 15, 1));
    applyStimulus(NOEN_FIRE,  ex(0, 0, 15, 1));
    applyStimulus(FIRE_R,     ex(1, 1, 15, 1));
    applyStimulus(DBG_IDLE,   ex(0, 0, 15, 1));

    // Asynchronous reset while in GAP with statistics nonzero
    doReset();
    applyStimulus(FIRE_N, ex(1, 1, 0, 0));
    applyStimulus(PEND_N, ex(1, 1, 1, 0));
    waitDrain();
    rst_ni = 1'b0;
    #1;
    stepId++;
    checkOutput(stepId, actual, 11'b0);
    @(negedge clk_i);
    {flush_i, debug_req_i, en_i, issue_valid_i, issue_ack_i, issue_is_mem_i, lsu_ready_i} = IDL_R;
    rst_ni = 1'b1;
    applyStimulus(FIRE_R, ex(1, 1, 0, 0));
    waitDrain();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
